// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32 funct3 size codes, the
// access FSM state type and small helpers that classify a request.
// Optional feature macro used by users of this package: LSU_MISALIGN_EXC_EN.
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Stores only exist for B/H/W; loads additionally have the unsigned forms.
    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // A halfword must sit on an even byte, a word on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            return off[0];
        end
        if (f3 == F3_W) begin
            return off != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// ----------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane steering for the load/store unit.
// Store path: st_funct3, st_offset, st_wdata -> st_be, st_data
//   (byte/halfword data replicated across lanes, enables select the lane).
// Load path:  ld_funct3, ld_offset, ld_rdata -> ld_data
//   (lane selected and sign/zero extended; word passed through).
// Halfword and word accesses ignore the low offset bits, which aligns
// misaligned addresses down.
// ----------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be   = 4'b0000;
        st_data = st_wdata;
        case (st_funct3)
            F3_B: begin
                st_be   = 4'b0001 << st_offset;
                st_data = {4{st_wdata[7:0]}};
            end
            F3_H: begin
                st_be   = st_offset[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_wdata[15:0]}};
            end
            F3_W: begin
                st_be   = 4'b1111;
            end
            default: begin
                st_be   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        byte_sel = ld_rdata[{ld_offset, 3'b000} +: 8];
        half_sel = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data  = 32'd0;
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            F3_W:    ld_data = ld_rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage behind the single-cycle datapath. Each load/store
// becomes one valid/ready transaction on a word-wide bus with byte enables;
// the core is stalled until the access retires in the DONE cycle.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_we/req_funct3/req_addr/req_wdata : access from the datapath
//   stall      : hold PC / register write while the access is in flight
//   load_data  : extended load result, held until the next load captures
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be       : bus request (word address)
//   mem_ready  : bus accepts the request this cycle
//   mem_rvalid/mem_rdata                           : bus read response
//   misalign   : misaligned-access flag, only with LSU_MISALIGN_EXC_EN
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned accesses skip the
// bus and raise misalign; otherwise they are aligned down and proceed).
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_MISALIGN_EXC_EN
    ,
    output logic              misalign
`endif
);

    lsu_state_t        state;
    lsu_state_t        state_next;

    logic [ADDR_W-3:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] load_data_q;

    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic [31:0]       ld_ext;

    logic              issue;
    logic              req_ok;
    logic              skip_bus;

    lsu_lane u_lane (
        .st_funct3 (req_funct3),
        .st_offset (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_ext)
    );

    assign issue  = (state == S_IDLE) && req_valid;
    assign req_ok = f3_valid(req_we, req_funct3);

`ifdef LSU_MISALIGN_EXC_EN
    logic req_misaligned;
    logic misalign_q;

    assign req_misaligned = is_misaligned(req_funct3, req_addr[1:0]);
    assign skip_bus       = !req_ok || req_misaligned;
    assign misalign       = misalign_q;
`else
    assign skip_bus       = !req_ok;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs are only live in REQ; stall drops exactly in DONE so the
    // core retires the instruction and the unit ignores its req_valid there.
    always_comb begin
        state_next = state;
        stall      = req_valid && (state != S_DONE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = skip_bus ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                mem_be  = be_q;
                if (mem_ready) begin
                    state_next = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request fields are captured once at issue so they stay stable while the
    // bus holds off; load_data only changes on a captured response or when an
    // invalid load retires with zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            off_q       <= 2'b00;
            f3_q        <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            if (issue) begin
                addr_q  <= req_addr[ADDR_W-1:2];
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                we_q    <= req_we;
                wdata_q <= st_data;
                be_q    <= st_be;
                if (!req_we && !req_ok) begin
                    load_data_q <= '0;
                end
            end
            if ((state == S_WAIT) && mem_rvalid) begin
                load_data_q <= ld_ext;
            end
`ifdef LSU_MISALIGN_EXC_EN
            misalign_q <= issue && req_ok && req_misaligned;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit. A byte-array memory answers the
// bus; a separate byte-array reference memory plus spec-level arithmetic
// provides every expected value. Honours LSU_MISALIGN_EXC_EN.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mis_obs;
`ifdef LSU_MISALIGN_EXC_EN
    logic        misalign;
    assign mis_obs = misalign;
`else
    assign mis_obs = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  bmem    [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_ld;

    int          dc;
    logic        sr, us, aw, ms;
    logic [13:0] aa;
    logic [3:0]  ab;
    logic [31:0] awd, ld;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef LSU_MISALIGN_EXC_EN
        , .misalign(misalign)
`endif
    );

    function automatic logic [31:0] bus_word(input logic [13:0] wa);
        return {bmem[{wa[5:0], 2'd3}], bmem[{wa[5:0], 2'd2}],
                bmem[{wa[5:0], 2'd1}], bmem[{wa[5:0], 2'd0}]};
    endfunction

    function automatic logic f3_ok(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic misal(input logic [2:0] f3, input logic [15:0] addr);
        if (f3 == 3'd1 || f3 == 3'd5) return addr % 2 != 0;
        if (f3 == 3'd2) return addr % 4 != 0;
        return 1'b0;
    endfunction

    function automatic logic bus_expected(input logic we, input logic [2:0] f3, input logic [15:0] addr);
`ifdef LSU_MISALIGN_EXC_EN
        return f3_ok(we, f3) && !misal(f3, addr);
`else
        return f3_ok(we, f3);
`endif
    endfunction

    function automatic int exp_done(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                                    input int rdly, input int vdly);
        if (!bus_expected(we, f3, addr)) return 1;
        return we ? 2 + rdly : 2 + rdly + vdly;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [15:0] addr);
        if (f3 == 3'd0) return 4'b0001 << (addr % 4);
        if (f3 == 3'd1) return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return {4{wd[7:0]}};
        if (f3 == 3'd1) return {2{wd[15:0]}};
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [15:0] addr);
        int a, h0, w0;
        logic [7:0]  b;
        logic [15:0] h;
        a  = int'(addr[7:0]);
        h0 = a - (a % 2);
        w0 = a - (a % 4);
        b  = ref_mem[a];
        h  = {ref_mem[h0 + 1], ref_mem[h0]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            3'd2:    return {ref_mem[w0 + 3], ref_mem[w0 + 2], ref_mem[w0 + 1], ref_mem[w0]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [15:0] addr, input logic [31:0] wd);
        int a;
        a = int'(addr[7:0]);
        if (f3 == 3'd0) begin
            ref_mem[a] = wd[7:0];
        end else if (f3 == 3'd1) begin
            a = a - (a % 2);
            ref_mem[a] = wd[7:0]; ref_mem[a + 1] = wd[15:8];
        end else begin
            a = a - (a % 4);
            for (int i = 0; i < 4; i++) ref_mem[a + i] = wd[8*i +: 8];
        end
    endtask

    task automatic set_word(input logic [15:0] addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bmem[{addr[7:2], 2'(i)}]    = w[8*i +: 8];
            ref_mem[{addr[7:2], 2'(i)}] = w[8*i +: 8];
        end
    endtask

    // Drives one access as the core and answers the bus; returns observations.
    // Entered and left one time unit after a rising edge.
    task automatic run_access(
        input logic we, input logic [2:0] f3, input logic [15:0] addr, input logic [31:0] wd,
        input int rdly, input int vdly,
        output int done_cyc, output logic saw_req, output logic unstable,
        output logic [13:0] a_addr, output logic [3:0] a_be, output logic [31:0] a_wd,
        output logic a_we, output logic [31:0] ldv, output logic misv);
        int req_cycles, acc;
        req_cycles = 0; acc = -1; done_cyc = -1; saw_req = 0; unstable = 0;
        a_addr = '0; a_be = '0; a_wd = '0; a_we = 0; ldv = '0; misv = 0;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 60; c++) begin
            mem_ready  = mem_req && (req_cycles >= rdly);
            mem_rvalid = 0;
            mem_rdata  = $urandom;
            if (acc >= 0 && !a_we && c == acc + vdly) begin
                mem_rvalid = 1;
                mem_rdata  = bus_word(a_addr);
            end
            #1;
            if (mem_req) begin
                if (!saw_req) begin
                    a_addr = mem_addr; a_be = mem_be; a_wd = mem_wdata; a_we = mem_we;
                end else if (mem_addr !== a_addr || mem_be !== a_be ||
                             mem_wdata !== a_wd || mem_we !== a_we) begin
                    unstable = 1;
                end
                saw_req = 1;
                req_cycles++;
                if (mem_ready) begin
                    acc = c;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) bmem[{mem_addr[5:0], 2'(i)}] = mem_wdata[8*i +: 8];
                    end
                end
            end
            if (!stall) begin
                done_cyc = c; ldv = load_data; misv = mis_obs;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 0; mem_ready = 0; mem_rvalid = 0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_be !== 4'b0) begin n_bad++; $display("FAIL reset_mem_be: got %b want 0000", mem_be); end
        n_cmp++; if (mem_addr !== 14'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (mis_obs !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", mis_obs); end
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        run_access(1, F3_W, 16'h0104, 32'hDEADBEEF, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        model_store(F3_W, 16'h0104, 32'hDEADBEEF);
        n_cmp++; if (aa !== 14'h041) begin n_bad++; $display("FAIL sw_addr: got %h want 041", aa); end
        n_cmp++; if (ab !== 4'b1111) begin n_bad++; $display("FAIL sw_be: got %b want 1111", ab); end
        n_cmp++; if (awd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", awd); end
        n_cmp++; if (aw !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b want 1", aw); end
        n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL sw_retire_cycle: got %0d want 2", dc); end
        n_cmp++; if (bus_word(14'h041) !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_memory: got %h want deadbeef", bus_word(14'h041)); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL sw_no_reissue: got mem_req %b want 0", mem_req); end
    endtask

    task automatic test_store_byte();
        run_access(1, F3_B, 16'h0103, 32'h000000A5, 1, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        model_store(F3_B, 16'h0103, 32'h000000A5);
        n_cmp++; if (ab !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b want 1000", ab); end
        n_cmp++; if (awd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", awd); end
        n_cmp++; if (aa !== 14'h040) begin n_bad++; $display("FAIL sb_addr: got %h want 040", aa); end
        n_cmp++; if (dc !== 3) begin n_bad++; $display("FAIL sb_retire_cycle: got %0d want 3", dc); end
        n_cmp++; if (ld !== last_ld) begin n_bad++; $display("FAIL sb_load_data_kept: got %h want %h", ld, last_ld); end
    endtask

    task automatic test_load_extend();
        set_word(16'h0100, 32'h12800000);
        run_access(0, F3_B, 16'h0102, 32'h0, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (ld !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_sign: got %h want ffffff80", ld); end
        n_cmp++; if (dc !== 3) begin n_bad++; $display("FAIL lb_retire_cycle: got %0d want 3", dc); end
        run_access(0, F3_BU, 16'h0102, 32'h0, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (ld !== 32'h00000080) begin n_bad++; $display("FAIL lbu_zero: got %h want 00000080", ld); end
        set_word(16'h0100, 32'h8001FFFF);
        run_access(0, F3_HU, 16'h0102, 32'h0, 0, 2, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (ld !== 32'h00008001) begin n_bad++; $display("FAIL lhu_zero: got %h want 00008001", ld); end
        run_access(0, F3_H, 16'h0102, 32'h0, 2, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (ld !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_sign: got %h want ffff8001", ld); end
        last_ld = 32'hFFFF8001;
    endtask

    task automatic test_ready_stall();
        logic [31:0] w;
        w = $urandom;
        set_word(16'h0200, w);
        run_access(0, F3_W, 16'h0200, 32'h0, 3, 2, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (us !== 1'b0) begin n_bad++; $display("FAIL lw_req_stable: got unstable=%b want 0", us); end
        n_cmp++; if (dc !== 7) begin n_bad++; $display("FAIL lw_retire_cycle: got %0d want 7", dc); end
        n_cmp++; if (ld !== w) begin n_bad++; $display("FAIL lw_data: got %h want %h", ld, w); end
        n_cmp++; if (aa !== 14'h080) begin n_bad++; $display("FAIL lw_addr: got %h want 080", aa); end
        last_ld = w;
    endtask

    task automatic test_misalign();
        set_word(16'h0100, 32'hCAFE8123);
        run_access(0, F3_H, 16'h0101, 32'h0, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
`ifdef LSU_MISALIGN_EXC_EN
        n_cmp++; if (sr !== 1'b0) begin n_bad++; $display("FAIL mis_no_req: got saw_req=%b want 0", sr); end
        n_cmp++; if (ms !== 1'b1) begin n_bad++; $display("FAIL mis_flag: got %b want 1", ms); end
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL mis_retire_cycle: got %0d want 1", dc); end
        n_cmp++; if (ld !== last_ld) begin n_bad++; $display("FAIL mis_load_kept: got %h want %h", ld, last_ld); end
        n_cmp++; if (mis_obs !== 1'b0) begin n_bad++; $display("FAIL mis_one_cycle: got %b want 0", mis_obs); end
`else
        n_cmp++; if (ab !== 4'b0011) begin n_bad++; $display("FAIL mis_lh_be: got %b want 0011", ab); end
        n_cmp++; if (aa !== 14'h040) begin n_bad++; $display("FAIL mis_lh_addr: got %h want 040", aa); end
        n_cmp++; if (ld !== 32'hFFFF8123) begin n_bad++; $display("FAIL mis_lh_data: got %h want ffff8123", ld); end
        last_ld = 32'hFFFF8123;
        run_access(1, F3_W, 16'h0106, 32'h13579BDF, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        model_store(F3_W, 16'h0106, 32'h13579BDF);
        n_cmp++; if (ab !== 4'b1111 || aa !== 14'h041) begin n_bad++; $display("FAIL mis_sw: got be %b addr %h want 1111 041", ab, aa); end
`endif
    endtask

    task automatic test_invalid_funct3();
        run_access(0, 3'd6, 16'h0010, 32'h0, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (sr !== 1'b0 || dc !== 1) begin n_bad++; $display("FAIL bad_load: got req %b cycle %0d want 0 1", sr, dc); end
        n_cmp++; if (ld !== 32'h0) begin n_bad++; $display("FAIL bad_load_data: got %h want 0", ld); end
        last_ld = 32'h0;
        run_access(1, 3'd5, 16'h0010, 32'hFFFFFFFF, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (sr !== 1'b0 || dc !== 1) begin n_bad++; $display("FAIL bad_store: got req %b cycle %0d want 0 1", sr, dc); end
    endtask

    task automatic test_reset_mid();
        set_word(16'h0300, 32'h5A5A1234);
        run_access(0, F3_W, 16'h0300, 32'h0, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        n_cmp++; if (ld !== 32'h5A5A1234) begin n_bad++; $display("FAIL rmid_pre_load: got %h want 5a5a1234", ld); end
        req_valid = 1; req_we = 0; req_funct3 = F3_W; req_addr = 16'h0300;
        @(posedge clk); #1;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0; req_valid = 0;
        reset = 0;
        #1;
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL rmid_load_cleared: got %h want 0", load_data); end
        @(posedge clk); #1;
        reset = 1; mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_rvalid = 0;
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL rmid_rvalid_ignored: got %h want 0", load_data); end
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rmid_idle: got req %b stall %b want 0 0", mem_req, stall); end
        last_ld = 32'h0;
        run_access(1, F3_B, 16'h0021, 32'h0000003C, 0, 1, dc, sr, us, aa, ab, awd, aw, ld, ms);
        model_store(F3_B, 16'h0021, 32'h0000003C);
        n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL rmid_recover: got %0d want 2", dc); end
    endtask

    task automatic test_random_back_to_back();
        logic        we, eb, emis;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wd, eld;
        int          rdly, vdly, edc, diffs;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if (we) f3 = 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            addr = 16'($urandom); wd = $urandom;
            rdly = $urandom_range(0, 3); vdly = $urandom_range(1, 3);
            eb   = bus_expected(we, f3, addr);
            edc  = exp_done(we, f3, addr, rdly, vdly);
            emis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            emis = f3_ok(we, f3) && misal(f3, addr);
`endif
            if (we)              eld = last_ld;
            else if (!f3_ok(we, f3)) eld = 32'h0;
            else if (!eb)        eld = last_ld;
            else                 eld = model_load(f3, addr);
            run_access(we, f3, addr, wd, rdly, vdly, dc, sr, us, aa, ab, awd, aw, ld, ms);
            if (we && eb) model_store(f3, addr, wd);
            last_ld = eld;
            n_cmp++; if (dc !== edc) begin n_bad++; $display("FAIL rnd%0d_retire: got %0d want %0d", i, dc, edc); end
            n_cmp++; if (sr !== eb) begin n_bad++; $display("FAIL rnd%0d_bus_req: got %b want %b", i, sr, eb); end
            n_cmp++; if (ld !== eld) begin n_bad++; $display("FAIL rnd%0d_load_data: got %h want %h", i, ld, eld); end
            n_cmp++; if (ms !== emis) begin n_bad++; $display("FAIL rnd%0d_misalign: got %b want %b", i, ms, emis); end
            if (eb) begin
                n_cmp++; if (aa !== addr[15:2]) begin n_bad++; $display("FAIL rnd%0d_addr: got %h want %h", i, aa, addr[15:2]); end
                n_cmp++; if (aw !== we || us !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_we_stable: got we %b unstable %b want %b 0", i, aw, us, we); end
                if (we) begin
                    n_cmp++; if (ab !== exp_be(f3, addr)) begin n_bad++; $display("FAIL rnd%0d_be: got %b want %b", i, ab, exp_be(f3, addr)); end
                    n_cmp++; if (awd !== exp_wdata(f3, wd)) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", i, awd, exp_wdata(f3, wd)); end
                end
            end
        end
        diffs = 0;
        for (int j = 0; j < 256; j++) if (bmem[j] !== ref_mem[j]) diffs++;
        n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL memory_image: got %0d differing bytes want 0", diffs); end
    endtask

    initial begin
        reset = 0; req_valid = 0; req_we = 0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; last_ld = 32'h0;
        for (int j = 0; j < 256; j++) begin
            bmem[j] = 8'($urandom);
            ref_mem[j] = bmem[j];
        end
        $display("[TB] load_store_unit bench start");
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_extend();
        test_ready_stall();
        test_misalign();
        test_invalid_funct3();
        test_reset_mid();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
